// File: rtl/wakey_wb_pkg.sv
// Shared types and constants for the Wishbone configuration master.
package wakey_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000;
    localparam int          WB_ADDR_BW         = 32;
    localparam int          WB_DATA_BW         = 32;

endpackage

// File: rtl/wb_watchdog.sv
// Counts bus cycles without acknowledge; expired_o flags the cycle in which
// the count reaches TIMEOUT_CYCLES while still enabled.
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (en_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the ack-less cycles already seen; this cycle would be the last allowed one.
    assign expired_o = en_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/wb_cfg_master.sv
// Wishbone classic single-transfer initiator driven by a command/response stream.
// Optional statistics counters are enabled by defining WB_CFG_MASTER_STATS_EN.
module wb_cfg_master
    import wakey_wb_pkg::*;
#(
    parameter int                 ADDR_BW        = WB_ADDR_BW,
    parameter int                 DATA_BW        = WB_DATA_BW,
    parameter int                 SEL_BW         = DATA_BW / 8,
    parameter logic [ADDR_BW-1:0] BASE_ADDR      = ADDR_BW'(WISHBONE_BASE_ADDR),
    parameter int                 TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [ADDR_BW-1:0] cmd_adr_i,
    input  logic [DATA_BW-1:0] cmd_dat_i,
    input  logic [SEL_BW-1:0]  cmd_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DATA_BW-1:0] rsp_dat_o,
    output logic               rsp_err_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [SEL_BW-1:0]  wbm_sel_o,
    output logic [ADDR_BW-1:0] wbm_adr_o,
    output logic [DATA_BW-1:0] wbm_dat_o,
    input  logic               wbm_ack_i,
    input  logic [DATA_BW-1:0] wbm_dat_i,
`ifdef WB_CFG_MASTER_STATS_EN
    output logic [15:0]        txn_count_o,
    output logic [15:0]        err_count_o,
`endif
    output logic               busy_o
);

    wb_state_e          state_q;
    logic               wbm_cyc_q;
    logic               wbm_stb_q;
    logic               wbm_we_q;
    logic [SEL_BW-1:0]  wbm_sel_q;
    logic [ADDR_BW-1:0] wbm_adr_q;
    logic [DATA_BW-1:0] wbm_dat_q;
    logic               rsp_valid_q;
    logic [DATA_BW-1:0] rsp_dat_q;
    logic               rsp_err_q;
    logic               wd_expired;

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q == IDLE),
        .en_i      ((state_q == BUS) && !wbm_ack_i),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wbm_cyc_q   <= 1'b0;
            wbm_stb_q   <= 1'b0;
            wbm_we_q    <= 1'b0;
            wbm_sel_q   <= '0;
            wbm_adr_q   <= '0;
            wbm_dat_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wbm_adr_q <= BASE_ADDR + cmd_adr_i;
                        wbm_we_q  <= cmd_we_i;
                        wbm_sel_q <= cmd_sel_i;
                        wbm_dat_q <= cmd_dat_i;
                        wbm_cyc_q <= 1'b1;
                        wbm_stb_q <= 1'b1;
                        state_q   <= BUS;
                    end
                end
                BUS: begin
                    // Ack is tested first so a late ack beats the watchdog.
                    if (wbm_ack_i) begin
                        wbm_cyc_q   <= 1'b0;
                        wbm_stb_q   <= 1'b0;
                        wbm_dat_q   <= '0;
                        rsp_dat_q   <= wbm_we_q ? '0 : wbm_dat_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (wd_expired) begin
                        wbm_cyc_q   <= 1'b0;
                        wbm_stb_q   <= 1'b0;
                        wbm_dat_q   <= '0;
                        rsp_dat_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_CFG_MASTER_STATS_EN
    logic [15:0] txn_count_q;
    logic [15:0] err_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txn_count_q <= 16'd0;
            err_count_q <= 16'd0;
        end else if (rsp_valid_q && rsp_ready_i) begin
            if (txn_count_q != 16'hFFFF) begin
                txn_count_q <= txn_count_q + 16'd1;
            end
            if (rsp_err_q && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign txn_count_o = txn_count_q;
    assign err_count_o = err_count_q;
`endif

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = wbm_cyc_q;
    assign wbm_stb_o   = wbm_stb_q;
    assign wbm_we_o    = wbm_we_q;
    assign wbm_sel_o   = wbm_sel_q;
    assign wbm_adr_o   = wbm_adr_q;
    assign wbm_dat_o   = wbm_dat_q;

endmodule

// File: tb/tb_wb_cfg_master.sv
// Self-checking bench for wb_cfg_master: scripted and random commands against
// a cycle-count model of the command/response protocol and a programmable slave.
module tb_wb_cfg_master;

    localparam int          TMO  = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy_o;
`ifdef WB_CFG_MASTER_STATS_EN
    logic [15:0] txn_count_o;
    logic [15:0] err_count_o;
`endif

    int total = 0;
    int bad   = 0;

    // Slave model: acks after ack_delay cycles of cyc (-1 = never).
    int          ack_delay   = 0;
    bit          ack_force   = 1'b0;
    logic [31:0] slave_rdata = 32'h0;
    int          stb_cnt     = 0;

    // Protocol-level reference counters.
    int exp_txn  = 0;
    int exp_errs = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } bus_t;
    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;
    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int          cyc_cycles = 0;
    bit          cyc_prev   = 1'b0;
    bit          unstable   = 1'b0;
    logic [31:0] cap_adr;
    logic [31:0] cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;

    wb_cfg_master #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i),
`ifdef WB_CFG_MASTER_STATS_EN
        .txn_count_o (txn_count_o),
        .err_count_o (err_count_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    assign wbm_ack_i = ack_force ||
                       (wbm_cyc_o && wbm_stb_o && (ack_delay >= 0) && (stb_cnt == ack_delay));
    assign wbm_dat_i = slave_rdata;

    always @(posedge clk) begin
        stb_cnt <= wbm_cyc_o ? stb_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (wbm_cyc_o && !cyc_prev) begin
            cyc_cycles = 1;
            unstable   = !wbm_stb_o;
            cap_adr    = wbm_adr_o;
            cap_dat    = wbm_dat_o;
            cap_sel    = wbm_sel_o;
            cap_we     = wbm_we_o;
        end else if (wbm_cyc_o) begin
            cyc_cycles++;
            if (!wbm_stb_o || wbm_adr_o !== cap_adr || wbm_dat_o !== cap_dat ||
                wbm_sel_o !== cap_sel || wbm_we_o !== cap_we)
                unstable = 1'b1;
        end
        cyc_prev = wbm_cyc_o;
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i)
            bus_q.push_back('{adr: wbm_adr_o, dat: wbm_dat_o, sel: wbm_sel_o, we: wbm_we_o});
        if (rsp_valid_o && rsp_ready_i)
            rsp_q.push_back('{dat: rsp_dat_o, err: rsp_err_o});
    end

    // One complete command: issue, bus phase, response (optionally back-pressured).
    task automatic do_cmd(input bit we, input logic [31:0] off, input logic [31:0] dat,
                          input logic [3:0] sel, input int delay, input logic [31:0] rdata,
                          input int hold, input string tag);
        bit          acc;
        int          n;
        bit          exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [31:0] exp_adr;
        logic [31:0] r_dat;
        logic        r_err;
        bit          hold_ok;
        exp_err = (delay < 0) || (delay >= TMO);
        exp_lat = exp_err ? TMO : delay + 1;
        exp_rd  = (exp_err || we) ? 32'h0 : rdata;
        exp_adr = BASE + off;
        ack_delay   = delay;
        slave_rdata = rdata;
        cmd_we_i    = we;
        cmd_adr_i   = off;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        cmd_valid_i = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = cmd_ready_o;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid_i = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL %s accept: cmd_ready never seen within 50 cycles", tag);
        end
        n = 0;
        while (!rsp_valid_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles after accept, want %0d", tag, n, exp_lat);
        end
        total++;
        if (cyc_cycles !== exp_lat || unstable || wbm_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL %s cyc: high %0d cycles (want %0d) unstable=%0b cyc_now=%0b",
                     tag, cyc_cycles, exp_lat, unstable, wbm_cyc_o);
        end
        total++;
        if (cap_adr !== exp_adr || cap_we !== we || cap_sel !== sel || (we && cap_dat !== dat)) begin
            bad++;
            $display("FAIL %s bus: adr=%h we=%0b sel=%h dat=%h want adr=%h we=%0b sel=%h dat=%h",
                     tag, cap_adr, cap_we, cap_sel, cap_dat, exp_adr, we, sel, dat);
        end
        total++;
        if (rsp_dat_o !== exp_rd || rsp_err_o !== exp_err) begin
            bad++;
            $display("FAIL %s rsp: dat=%h err=%0b want dat=%h err=%0b",
                     tag, rsp_dat_o, rsp_err_o, exp_rd, exp_err);
        end
        r_dat   = rsp_dat_o;
        r_err   = rsp_err_o;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            cmd_valid_i = 1'b1;
            cmd_adr_i   = 32'hBAD0;
            @(posedge clk); #1;
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== r_dat || rsp_err_o !== r_err ||
                cmd_ready_o !== 1'b0 || wbm_cyc_o !== 1'b0)
                hold_ok = 1'b0;
        end
        if (hold > 0) begin
            total++;
            if (!hold_ok) begin
                bad++;
                $display("FAIL %s backpressure: rsp not held or new cmd started (valid=%0b cyc=%0b)",
                         tag, rsp_valid_o, wbm_cyc_o);
            end
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        exp_txn++;
        if (exp_err) exp_errs++;
        total++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0 ||
            wbm_cyc_o !== 1'b0 || wbm_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL %s release: valid=%0b ready=%0b busy=%0b cyc=%0b wdat=%h want 0 1 0 0 0",
                     tag, rsp_valid_o, cmd_ready_o, busy_o, wbm_cyc_o, wbm_dat_o);
        end
`ifdef WB_CFG_MASTER_STATS_EN
        total++;
        if (txn_count_o !== 16'(exp_txn) || err_count_o !== 16'(exp_errs)) begin
            bad++;
            $display("FAIL %s stats: txn=%0d err=%0d want txn=%0d err=%0d",
                     tag, txn_count_o, err_count_o, exp_txn, exp_errs);
        end
`endif
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h0;
        cmd_dat_i   = 32'h0;
        cmd_sel_i   = 4'h0;
        rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk); #1;
        total++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 ||
            rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_dat_o !== 32'h0 ||
            wbm_dat_o !== 32'h0 || wbm_adr_o !== 32'h0 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'h0) begin
            bad++;
            $display("FAIL reset: ready=%0b busy=%0b cyc=%0b stb=%0b rv=%0b err=%0b rdat=%h wdat=%h adr=%h",
                     cmd_ready_o, busy_o, wbm_cyc_o, wbm_stb_o, rsp_valid_o, rsp_err_o,
                     rsp_dat_o, wbm_dat_o, wbm_adr_o);
        end
    endtask

    task automatic test_write();
        do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 32'h5555AAAA, 0, "write");
    endtask

    task automatic test_read();
        do_cmd(1'b0, 32'h24, 32'h0, 4'hF, 0, 32'h12345678, 0, "read");
    endtask

    task automatic test_timeout();
        do_cmd(1'b0, 32'h40, 32'h0, 4'hF, -1, 32'hCAFEF00D, 0, "timeout");
    endtask

    task automatic test_backpressure();
        do_cmd(1'b0, 32'h80, 32'h0, 4'h3, 1, 32'hA5A5_0001, 5, "bp_first");
        do_cmd(1'b1, 32'h84, 32'h0BAD_CAFE, 4'hC, 2, 32'h0, 0, "bp_second");
    endtask

    task automatic test_stray_ack();
        bit ok;
        ok = 1'b1;
        ack_force = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (wbm_cyc_o !== 1'b0 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
        end
        ack_force = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stray_ack: idle ack caused activity cyc=%0b rv=%0b busy=%0b",
                     wbm_cyc_o, rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_reset_mid_bus();
        bit ok;
        int n;
        ack_delay   = -1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 32'h60;
        cmd_dat_i   = 32'h1111_2222;
        cmd_sel_i   = 4'hF;
        cmd_valid_i = 1'b1;
        n = 0;
        while (!cmd_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(posedge clk); #3;
        total++;
        if (wbm_cyc_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid setup: cyc=%0b want 1 before reset", wbm_cyc_o);
        end
        rst_i = 1'b1;
        #1;
        total++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid_o !== 1'b0 ||
            busy_o !== 1'b0 || wbm_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid async: cyc=%0b stb=%0b rv=%0b busy=%0b wdat=%h want all 0",
                     wbm_cyc_o, wbm_stb_o, rsp_valid_o, busy_o, wbm_dat_o);
        end
        @(negedge clk);
        rst_i    = 1'b0;
        exp_txn  = 0;
        exp_errs = 0;
        ok = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid_o !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready_o !== 1'b1) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_mid drop: response or cycle after reset rv=%0b cyc=%0b ready=%0b",
                     rsp_valid_o, wbm_cyc_o, cmd_ready_o);
        end
        do_cmd(1'b0, 32'h64, 32'h0, 4'hF, 2, 32'h7777_8888, 0, "rst_mid_after");
    endtask

    task automatic test_back_to_back();
        logic [31:0] offs[8];
        logic [31:0] dats[8];
        int          b0;
        int          r0;
        int          k;
        int          n;
        bit          acc;
        for (int i = 0; i < 8; i++) begin
            offs[i] = $urandom & 32'h0000_FFFC;
            dats[i] = $urandom;
        end
        b0 = bus_q.size();
        r0 = rsp_q.size();
        ack_delay   = 0;
        rsp_ready_i = 1'b1;
        k = 0;
        cmd_we_i    = 1'b1;
        cmd_sel_i   = 4'hF;
        cmd_adr_i   = offs[0];
        cmd_dat_i   = dats[0];
        cmd_valid_i = 1'b1;
        n = 0;
        while (k < 8 && n < 200) begin
            acc = cmd_ready_o;
            @(posedge clk); #1;
            n++;
            if (acc) begin
                k++;
                if (k < 8) begin
                    cmd_adr_i = offs[k];
                    cmd_dat_i = dats[k];
                end else begin
                    cmd_valid_i = 1'b0;
                end
            end
        end
        cmd_valid_i = 1'b0;
        n = 0;
        while (rsp_q.size() - r0 < 8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        rsp_ready_i = 1'b0;
        exp_txn += 8;
        total++;
        if (rsp_q.size() - r0 != 8 || bus_q.size() - b0 != 8) begin
            bad++;
            $display("FAIL b2b count: responses=%0d transfers=%0d want 8 8",
                     rsp_q.size() - r0, bus_q.size() - b0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (bus_q[b0+i].adr !== BASE + offs[i] || bus_q[b0+i].dat !== dats[i] ||
                    bus_q[b0+i].we !== 1'b1 || rsp_q[r0+i].dat !== 32'h0 || rsp_q[r0+i].err !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b[%0d]: adr=%h dat=%h we=%0b rdat=%h err=%0b want adr=%h dat=%h",
                             i, bus_q[b0+i].adr, bus_q[b0+i].dat, bus_q[b0+i].we,
                             rsp_q[r0+i].dat, rsp_q[r0+i].err, BASE + offs[i], dats[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 24; i++) begin
            d = int'($urandom_range(0, 6));
            if (d == 6) d = -1;
            do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                   d, $urandom, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_stray_ack();
        test_backpressure();
        test_reset_mid_bus();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
